noc_link_arbiter: RTL and testbench
===================================

# noc_link_arbiter

Round-robin, packet-atomic arbiter that lets N_REQ requesters share one credit-flow-controlled 16-bit NoC output link (enable/data out, credit back). It sits at each router output port, between the input-side buffers and the link's send side. It tracks downstream buffer credits and issues a flit only when a credit is available. Once a requester wins, it keeps the link until its tail flit has been sent.

## Interface
- N_REQ, 4: number of requesters (≥2).
- CREDIT_MAX, 4: downstream buffer depth; the credit count resets to this value.
- CW, $clog2(CREDIT_MAX+1): credit counter width (derived, not overridden).

- clk  in  1  link clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- req  in  N_REQ  requester i has a valid flit on req_data slice i.
- req_last  in  N_REQ  that flit is the packet tail.
- req_data  in  16*N_REQ  flit of requester i in bits [16i+15:16i].
- gnt  out  N_REQ  one-hot or zero, combinational; a flit transfers when req[i] & gnt[i].
- enable  out  1  registered; a flit is on data this cycle.
- data  out  16  registered outgoing flit.
- credit  in  1  one-cycle pulse; downstream freed one buffer slot.
- credit_cnt  out  CW  current credits available.
- credit_err  out  1  sticky; a credit returned while credit_cnt==CREDIT_MAX.

## Operation
- The FSM has two states: IDLE and LOCKED. It holds an owner register (index) and a round-robin pointer rr_ptr (index of the last packet winner).
- A send is allowed (can_send) when credit_cnt != 0.
- IDLE:
  - If can_send and any req bit is set, grant the first requester searching rr_ptr+1, rr_ptr+2, … mod N_REQ.
  - On that transfer, rr_ptr ← winner.
  - If req_last of the winner is set, stay IDLE (single-flit packet).
  - Otherwise owner ← winner and move to LOCKED.
- LOCKED:
  - gnt[owner] = can_send & req[owner]. All other gnt bits are 0.
  - If the owner drops req, no flit is sent and the state stays LOCKED (bubble). Other requesters never interleave.
  - A transfer with req_last set moves the FSM to IDLE. The next arbitration starts the following cycle.
- gnt is never asserted when credit_cnt==0.
- Transfer cycle: the next state is enable←1 and data←the granted slice. Otherwise enable←0 and data holds its value.
- Credit counter, per cycle:
  - Transfer only: decrement by 1.
  - credit only: increment by 1.
  - Both: unchanged.
  - Neither: unchanged.
- Credit overflow (credit with no transfer while credit_cnt==CREDIT_MAX): credit_cnt stays saturated and credit_err←1 until rst.
- Reset values:
  - State: IDLE.
  - rr_ptr: N_REQ-1, so requester 0 has first priority.
  - owner: 0.
  - enable: 0.
  - data: 16'h0.
  - credit_cnt: CREDIT_MAX.
  - credit_err: 0.
  - gnt: 0 while rst is high.
- Reset mid-packet abandons the packet immediately. The requester is responsible for resending.

## Timing
- gnt is combinational from req, req_last, state, owner, rr_ptr and credit_cnt. It must not depend combinationally on the credit input.
- Latency is 1 cycle: a flit accepted in cycle t appears on enable/data in cycle t+1.
- A credit pulse in cycle t raises credit_cnt in t+1. A flit can use that credit in t+1 at the earliest.
- credit_cnt reflects a transfer in cycle t from cycle t+1 onward.
- Maximum throughput is 1 flit/cycle, sustained as long as credit_cnt>0.
- With CREDIT_MAX credits and a round-trip of R cycles, the link stalls when R > CREDIT_MAX. This is expected behaviour, not an error.
- Back-to-back packets:
  - From different requesters: no idle cycle is forced beyond the IDLE re-arbitration in the cycle after the tail.
  - A single-flit packet followed by another arbitration in the next cycle is permitted.

## Test plan
- Reset then single request:
  - Stimulus: after rst, req=4'b0001, last=1, data=16'hA5A5.
  - Required response: gnt=0001 in the same cycle. In the next cycle enable=1, data=A5A5 and credit_cnt=3.
- Round-robin fairness:
  - Stimulus: all 4 requesters continuously send single-flit packets, with credit returned every cycle.
  - Required response: grant order 0,1,2,3,0,…, and credit_cnt stays 4 after the first cycle.
- Packet atomicity:
  - Stimulus: req0 sends a 3-flit packet and req1 requests throughout.
  - Required response: three consecutive gnt=0001, then gnt=0010.
  - Stimulus: req0 deasserts mid-packet.
  - Required response: gnt=0000 and enable=0 (bubble); req1 is not granted.
- Credit exhaustion:
  - Stimulus: no credits returned, req0 streams.
  - Required response: exactly 4 flits sent, then gnt=0 with credit_cnt=0.
  - Stimulus: one credit pulse.
  - Required response: exactly one more flit.
- Simultaneous and overflow:
  - Stimulus: transfer and credit in the same cycle.
  - Required response: credit_cnt unchanged.
  - Stimulus: credit with no transfer while credit_cnt=4.
  - Required response: credit_err=1 stays set, and credit_cnt=4.
- Asynchronous reset mid-packet:
  - Stimulus: assert rst between clock edges during a LOCKED packet.
  - Required response: enable=0 and gnt=0 immediately, and credit_cnt=4. After release, requester 0 wins first.

Source files
------------

// File: rtl/noc_link_arbiter_if.sv
// Requester/link bundle for the NoC output-port arbiter.
// slave = arbiter side, master = requesters plus downstream credit source.
interface noc_link_arbiter_if #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned CREDIT_MAX = 4
);
    localparam int unsigned CW = $clog2(CREDIT_MAX + 1);

    logic [N_REQ-1:0]    req;
    logic [N_REQ-1:0]    req_last;
    logic [16*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]    gnt;
    logic                enable;
    logic [15:0]         data;
    logic                credit;
    logic [CW-1:0]       credit_cnt;
    logic                credit_err;

    modport master (
        output req, req_last, req_data, credit,
        input  gnt, enable, data, credit_cnt, credit_err
    );

    modport slave (
        input  req, req_last, req_data, credit,
        output gnt, enable, data, credit_cnt, credit_err
    );
endinterface

// File: rtl/noc_link_arbiter.sv
// Round-robin, packet-atomic arbiter for one credit-flow-controlled 16-bit link.
// A requester that wins keeps the link until its tail flit has been sent.
module noc_link_arbiter #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned CREDIT_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    noc_link_arbiter_if.slave    link
);
    localparam int unsigned CW = $clog2(CREDIT_MAX + 1);
    localparam int unsigned IW = $clog2(N_REQ);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t         state;
    logic [IW-1:0]  owner;
    logic [IW-1:0]  rr_ptr;
    logic [IW-1:0]  pick;
    logic [IW-1:0]  cand;
    logic           pick_valid;
    logic           can_send;
    logic [N_REQ-1:0] gnt_c;
    logic           xfer;
    logic           xfer_last;
    logic [15:0]    xfer_data;
    logic           enable_reg;
    logic [15:0]    data_reg;
    logic [CW-1:0]  credit_cnt_reg;
    logic           credit_err_reg;

    // Credits come only from the registered count, never from the credit pulse.
    assign can_send = (credit_cnt_reg != '0);

    // Round-robin search starting just after the last packet winner.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        cand       = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = IW'((32'(rr_ptr) + k) % N_REQ);
            if (!pick_valid && link.req[cand]) begin
                pick       = cand;
                pick_valid = 1'b1;
            end
        end
    end

    // Grant: arbitrate in IDLE, follow the owner only while LOCKED.
    always_comb begin
        gnt_c = '0;
        if (!rst && can_send) begin
            if (state == IDLE) begin
                if (pick_valid) gnt_c[pick] = 1'b1;
            end else begin
                gnt_c[owner] = link.req[owner];
            end
        end
    end

    // Transfer decode and payload select from the one-hot grant.
    always_comb begin
        xfer      = |(gnt_c & link.req);
        xfer_last = |(gnt_c & link.req_last);
        xfer_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_c[i]) xfer_data = xfer_data | link.req_data[16*i +: 16];
        end
    end

    // Packet FSM, round-robin pointer, output register and credit accounting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            owner          <= '0;
            rr_ptr         <= IW'(N_REQ - 1);
            enable_reg     <= 1'b0;
            data_reg       <= 16'h0;
            credit_cnt_reg <= CW'(CREDIT_MAX);
            credit_err_reg <= 1'b0;
        end else begin
            enable_reg <= xfer;
            if (xfer) data_reg <= xfer_data;

            case (state)
                IDLE: begin
                    if (xfer) begin
                        rr_ptr <= pick;
                        if (!xfer_last) begin
                            owner <= pick;
                            state <= LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (xfer && xfer_last) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (xfer && !link.credit) begin
                credit_cnt_reg <= credit_cnt_reg - CW'(1);
            end else if (!xfer && link.credit) begin
                if (credit_cnt_reg == CW'(CREDIT_MAX)) credit_err_reg <= 1'b1;
                else                                    credit_cnt_reg <= credit_cnt_reg + CW'(1);
            end
        end
    end

    assign link.gnt        = gnt_c;
    assign link.enable     = enable_reg;
    assign link.data       = data_reg;
    assign link.credit_cnt = credit_cnt_reg;
    assign link.credit_err = credit_err_reg;
endmodule

// File: tb/tb_noc_link_arbiter.sv
// Bench for noc_link_arbiter: directed scenarios plus random traffic,
// all checked against a cycle-level behavioural model of the link.
module tb_noc_link_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned CM = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;

    noc_link_arbiter_if #(.N_REQ(N), .CREDIT_MAX(CM)) bus ();

    noc_link_arbiter #(.N_REQ(N), .CREDIT_MAX(CM)) dut (
        .clk  (clk),
        .rst  (rst),
        .link (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: owner < 0 means no packet in progress.
    int          m_credits;
    int          m_rr;
    int          m_owner;
    bit          m_err;
    bit          m_en;
    logic [15:0] m_data;
    logic [N-1:0] last_gnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_credits = CM;
        m_rr      = N - 1;
        m_owner   = -1;
        m_err     = 1'b0;
        m_en      = 1'b0;
        m_data    = 16'h0;
    endtask

    function automatic logic [N-1:0] model_grant();
        logic [N-1:0] g;
        g = '0;
        if (m_credits == 0) return g;
        if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (m_rr + k) % N;
                if (bus.req[i]) begin
                    g[i] = 1'b1;
                    return g;
                end
            end
        end else if (bus.req[m_owner]) begin
            g[m_owner] = 1'b1;
        end
        return g;
    endfunction

    task automatic drive(input logic [N-1:0] r, input logic [N-1:0] l, input logic c);
        bus.req      = r;
        bus.req_last = l;
        bus.credit   = c;
    endtask

    // One clock: check gnt mid-cycle, advance the model, check registered outputs.
    task automatic cycle();
        logic [N-1:0] eg;
        int w;
        @(negedge clk);
        eg       = model_grant();
        last_gnt = bus.gnt;
        check("gnt", 32'(bus.gnt), 32'(eg));
        @(posedge clk);
        w = -1;
        for (int i = 0; i < N; i++) if (eg[i]) w = i;
        m_en = (w >= 0);
        if (w >= 0) begin
            m_data = bus.req_data[16*w +: 16];
            if (m_owner < 0) begin
                m_rr = w;
                if (!bus.req_last[w]) m_owner = w;
            end else if (bus.req_last[w]) begin
                m_owner = -1;
            end
        end
        if (m_en && !bus.credit) m_credits--;
        else if (!m_en && bus.credit) begin
            if (m_credits == CM) m_err = 1'b1;
            else                 m_credits++;
        end
        #1;
        check("enable",     32'(bus.enable),     32'(m_en));
        check("data",       32'(bus.data),       32'(m_data));
        check("credit_cnt", 32'(bus.credit_cnt), 32'(m_credits));
        check("credit_err", 32'(bus.credit_err), 32'(m_err));
    endtask

    // Raise rst wherever we are in the cycle; outputs must clear at once.
    task automatic apply_reset();
        rst = 1'b1;
        #1;
        check("rst_gnt",    32'(bus.gnt),        32'(0));
        check("rst_enable", 32'(bus.enable),     32'(0));
        check("rst_data",   32'(bus.data),       32'(0));
        check("rst_cnt",    32'(bus.credit_cnt), 32'(CM));
        check("rst_err",    32'(bus.credit_err), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int sent;
        int pct;
        drive('0, '0, 1'b0);
        bus.req_data = {16'hD003, 16'hC002, 16'hB001, 16'hA5A5};
        model_reset();
        #2;
        apply_reset();

        // Single-flit request from requester 0.
        drive(4'b0001, 4'b0001, 1'b0);
        cycle();
        check("single_gnt",  32'(last_gnt),       32'(4'b0001));
        check("single_data", 32'(bus.data),       32'(16'hA5A5));
        check("single_cnt",  32'(bus.credit_cnt), 32'(3));

        // Round-robin among four continuous single-flit requesters.
        apply_reset();
        drive(4'b1111, 4'b1111, 1'b1);
        for (int k = 0; k < 8; k++) begin
            cycle();
            check("rr_order", 32'(last_gnt), 32'(4'b0001 << (k % 4)));
            check("rr_cnt",   32'(bus.credit_cnt), 32'(CM));
        end

        // Packet atomicity with an owner bubble; requester 1 waits throughout.
        apply_reset();
        drive(4'b0011, 4'b0000, 1'b0);
        cycle();
        check("atom_f0", 32'(last_gnt), 32'(4'b0001));
        drive(4'b0010, 4'b0000, 1'b0);
        cycle();
        check("bubble_gnt", 32'(last_gnt),   32'(4'b0000));
        check("bubble_en",  32'(bus.enable), 32'(0));
        drive(4'b0011, 4'b0000, 1'b0);
        cycle();
        check("atom_f1", 32'(last_gnt), 32'(4'b0001));
        drive(4'b0011, 4'b0001, 1'b0);
        cycle();
        check("atom_f2", 32'(last_gnt), 32'(4'b0001));
        drive(4'b0011, 4'b0000, 1'b0);
        cycle();
        check("atom_next", 32'(last_gnt), 32'(4'b0010));

        // Credit exhaustion, then a single returned credit.
        apply_reset();
        drive(4'b0001, 4'b0000, 1'b0);
        sent = 0;
        for (int k = 0; k < 7; k++) begin
            cycle();
            sent += int'(bus.enable);
        end
        check("exhaust_sent", 32'(sent),           32'(4));
        check("exhaust_cnt",  32'(bus.credit_cnt), 32'(0));
        drive(4'b0001, 4'b0000, 1'b1);
        cycle();
        drive(4'b0001, 4'b0000, 1'b0);
        sent = 0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            sent += int'(bus.enable);
        end
        check("one_credit_sent", 32'(sent), 32'(1));

        // Simultaneous transfer and credit, then overflow.
        apply_reset();
        drive(4'b0001, 4'b0001, 1'b0);
        cycle();
        drive(4'b0001, 4'b0001, 1'b1);
        cycle();
        check("simul_cnt", 32'(bus.credit_cnt), 32'(3));
        drive(4'b0000, 4'b0000, 1'b1);
        cycle();
        cycle();
        check("ovf_err", 32'(bus.credit_err), 32'(1));
        check("ovf_cnt", 32'(bus.credit_cnt), 32'(CM));
        drive(4'b0000, 4'b0000, 1'b0);
        cycle();
        cycle();
        check("ovf_sticky", 32'(bus.credit_err), 32'(1));

        // Asynchronous reset in the middle of a LOCKED packet.
        apply_reset();
        drive(4'b0011, 4'b0000, 1'b0);
        cycle();
        cycle();
        #2;
        apply_reset();
        drive(4'b0011, 4'b0011, 1'b0);
        cycle();
        check("post_rst_winner", 32'(last_gnt), 32'(4'b0001));

        // Random traffic at two credit-return rates, with occasional resets.
        for (int phase = 0; phase < 2; phase++) begin
            pct = (phase == 0) ? 60 : 25;
            apply_reset();
            for (int k = 0; k < 1500; k++) begin
                bus.req      = N'($urandom);
                bus.req_last = N'($urandom) & N'($urandom);
                bus.req_data = {N{16'($urandom)}} ^ {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
                bus.credit   = ($urandom % 100) < pct;
                cycle();
                if (k % 400 == 399) begin
                    #2;
                    apply_reset();
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
